fpd_arbiter: RTL and testbench
==============================

Name: fpd_arbiter

Overview:
Shares one floating_point_divider instance between N requesters. Each requester uses a valid/ready handshake to submit an operand pair. The block grants round-robin and registers operands onto the divider inputs. It waits a configurable divider latency, then captures the quotient and the overflow/underflow/divide-by-zero flags. The result is returned to the granted requester with its own valid/ready handshake. It sits between client datapaths and the divider core; one operation is outstanding at a time.

Parameters:
EXP_WIDTH, 8, exponent width (from fpd_pkg)
MANTISSA_WIDTH, 23, mantissa width (from fpd_pkg)
N_REQ, 4, number of requesters (2..8)
FPD_LATENCY, 0, divider result delay in cycles after operands are applied (0 = combinational core)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req_valid_in  input  N_REQ  per-requester operation request
req_ready_out  output  N_REQ  one-hot request accept
req_a_in  input  N_REQ*W  packed dividends, W=EXP_WIDTH+MANTISSA_WIDTH+1; slice i belongs to requester i
req_b_in  input  N_REQ*W  packed divisors
rsp_valid_out  output  N_REQ  one-hot response valid
rsp_ready_in  input  N_REQ  per-requester response accept
rsp_result_out  output  W  captured quotient
rsp_overflow_out  output  1  captured overflow flag
rsp_underflow_out  output  1  captured underflow flag
rsp_dbz_out  output  1  captured divide-by-zero flag
grant_id_out  output  $clog2(N_REQ)  index of current or last grantee
busy_out  output  1  high in any state except IDLE
fpd_a_out  output  W  divider operand a
fpd_b_out  output  W  divider operand b
fpd_result_in  input  W  divider quotient
fpd_overflow_in, fpd_underflow_in, fpd_dbz_in  input  1 each  divider flags

Behaviour:
- Clocking and reset: one clock (clock); reset is synchronous, active-high.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - last_grant = N_REQ-1, so requester 0 has first priority.
  - Counter 0.
- Reset asserted mid-operation: the operation is abandoned, no response is issued, and the block returns to IDLE next edge.
- States: IDLE -> WAIT -> RESPOND -> IDLE.
- IDLE:
  - Winner g = first requester with req_valid_in set, searching from (last_grant+1) mod N_REQ upward with wrap.
  - req_ready_out[g] is combinationally 1 in the same cycle; all other ready bits are 0.
  - At the edge: fpd_a_out/fpd_b_out load slice g; grant_id_out=g; counter=FPD_LATENCY; state goes to WAIT.
  - No valid requests: stay in IDLE with outputs held.
- WAIT:
  - fpd_a_out/fpd_b_out are held stable.
  - req_ready_out is all zero.
  - If counter==0: capture fpd_result_in and the three flags into the rsp_* registers, then go to RESPOND.
  - Otherwise decrement the counter.
- RESPOND:
  - rsp_valid_out[g]=1; data and flags are held stable until rsp_ready_in[g]=1.
  - At the accepting edge: last_grant=g, rsp_valid_out cleared, state goes to IDLE.
  - rsp_ready_in bits of non-grantees are ignored.
- Latency: request handshake at edge k -> rsp_valid_out at cycle k+FPD_LATENCY+2 (the captured data includes one registered operand stage).
- Throughput: at most one operation per FPD_LATENCY+3 cycles with zero response backpressure.
- Handshake rules:
  - A requester whose valid drops before its grant loses nothing.
  - Its operands are sampled only on the handshake edge.
- Fairness: after serving g, priority rotates to g+1, so no requester waits more than N_REQ-1 grants.
- Flags are passed through unchanged; the block performs no arithmetic.

Decomposition:
- fpd_pkg holds:
  - EXP_WIDTH and MANTISSA_WIDTH;
  - FP_WIDTH=EXP_WIDTH+MANTISSA_WIDTH+1;
  - fpd_arb_state_t enum {IDLE, WAIT, RESPOND};
  - fpd_rsp_t struct {result, overflow, underflow, dbz}.
- Sub-module fpd_rr_arbiter: combinational round-robin pick from (request vector, last_grant) giving a one-hot grant plus index. It is reusable elsewhere.

Test Plan:
1. Single request, FPD_LATENCY=0: requester 0 sends a=0x40C00000 (6.0), b=0x40000000 (2.0) -> rsp_valid_out=0001 two cycles after the handshake, rsp_result_out=0x40400000, all flags 0.
2. Divide by zero: requester 2 sends a=0x3F800000, b=0x00000000 -> rsp_dbz_out=1, rsp_valid_out=0100.
3. All four valid at once with rsp_ready_in tied high -> grants in order 0,1,2,3,0; each ready_out is one-hot; req_ready_out is never asserted in WAIT/RESPOND.
4. Backpressure: hold rsp_ready_in[1]=0 for 5 cycles -> rsp_valid_out[1] and the result stay stable, busy_out=1, no new grant; release -> IDLE next edge.
5. FPD_LATENCY=3 with a divider model delayed 3 cycles: fpd_a_out is stable for 4 WAIT cycles, and the result arrives at handshake+5.
6. Reset asserted during WAIT -> next edge: IDLE, all outputs 0, no rsp_valid_out pulse; the following request is granted to requester 0.

Source files
------------

// File: rtl/fpd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpd_pkg
// Brief    : Shared widths, state encoding and response record for the
//            floating-point divider arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package fpd_pkg;

    localparam int EXP_WIDTH      = 8;
    localparam int MANTISSA_WIDTH = 23;
    localparam int FP_WIDTH       = EXP_WIDTH + MANTISSA_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } fpd_arb_state_t;

    typedef struct packed {
        logic [FP_WIDTH-1:0] result;
        logic                overflow;
        logic                underflow;
        logic                dbz;
    } fpd_rsp_t;

endpackage
`default_nettype wire

// File: rtl/fpd_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpd_rr_arbiter
// Brief    : Combinational round-robin picker. Searches the request vector
//            starting just above last_grant, wrapping, and returns the first
//            hit as a one-hot vector plus its index.
// Revision : 1.0 - initial release
// ============================================================================
module fpd_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] cand;

    // First requester at or after last_grant+1 (mod N) wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IDX_W'((int'(last_grant) + i) % N);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fpd_arbiter
// Brief    : Shares one floating-point divider between N_REQ requesters.
//            Round-robin grant, registered operands, fixed divider latency
//            wait, captured result returned over a per-requester handshake.
//            One operation is outstanding at a time.
// Revision : 1.0 - initial release
// ============================================================================
module fpd_arbiter
    import fpd_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int FPD_LATENCY = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req_valid_in,
    output logic [N_REQ-1:0]             req_ready_out,
    input  logic [N_REQ*FP_WIDTH-1:0]    req_a_in,
    input  logic [N_REQ*FP_WIDTH-1:0]    req_b_in,
    output logic [N_REQ-1:0]             rsp_valid_out,
    input  logic [N_REQ-1:0]             rsp_ready_in,
    output logic [FP_WIDTH-1:0]          rsp_result_out,
    output logic                         rsp_overflow_out,
    output logic                         rsp_underflow_out,
    output logic                         rsp_dbz_out,
    output logic [$clog2(N_REQ)-1:0]     grant_id_out,
    output logic                         busy_out,
    output logic [FP_WIDTH-1:0]          fpd_a_out,
    output logic [FP_WIDTH-1:0]          fpd_b_out,
    input  logic [FP_WIDTH-1:0]          fpd_result_in,
    input  logic                         fpd_overflow_in,
    input  logic                         fpd_underflow_in,
    input  logic                         fpd_dbz_in
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = (FPD_LATENCY > 0) ? $clog2(FPD_LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(FPD_LATENCY);

    fpd_arb_state_t     state;
    logic [IDX_W-1:0]   last_grant;
    logic [CNT_W-1:0]   counter;
    fpd_rsp_t           rsp;

    logic [N_REQ-1:0]   pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic [FP_WIDTH-1:0] a_slice [N_REQ];
    logic [FP_WIDTH-1:0] b_slice [N_REQ];

    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
            assign a_slice[i] = req_a_in[i*FP_WIDTH +: FP_WIDTH];
            assign b_slice[i] = req_b_in[i*FP_WIDTH +: FP_WIDTH];
        end
    endgenerate

    fpd_rr_arbiter #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req         (req_valid_in),
        .last_grant  (last_grant),
        .grant       (pick_onehot),
        .grant_idx   (pick_idx),
        .grant_valid (pick_any)
    );

    // Accept is offered only while idle and out of reset, so every output
    // reads zero whenever reset is held.
    assign req_ready_out     = (state == IDLE && !reset) ? pick_onehot : '0;
    assign busy_out          = (state != IDLE);
    assign rsp_result_out    = rsp.result;
    assign rsp_overflow_out  = rsp.overflow;
    assign rsp_underflow_out = rsp.underflow;
    assign rsp_dbz_out       = rsp.dbz;

    // Control FSM: grant and load operands, count down the divider latency,
    // capture the result, then hold it until the grantee accepts.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            last_grant    <= IDX_W'(N_REQ - 1);
            counter       <= '0;
            rsp           <= '0;
            rsp_valid_out <= '0;
            grant_id_out  <= '0;
            fpd_a_out     <= '0;
            fpd_b_out     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        fpd_a_out    <= a_slice[pick_idx];
                        fpd_b_out    <= b_slice[pick_idx];
                        grant_id_out <= pick_idx;
                        counter      <= LAT_LOAD;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (counter == '0) begin
                        rsp.result    <= fpd_result_in;
                        rsp.overflow  <= fpd_overflow_in;
                        rsp.underflow <= fpd_underflow_in;
                        rsp.dbz       <= fpd_dbz_in;
                        rsp_valid_out <= N_REQ'(1) << grant_id_out;
                        state         <= RESPOND;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                RESPOND: begin
                    if (rsp_ready_in[grant_id_out]) begin
                        last_grant    <= grant_id_out;
                        rsp_valid_out <= '0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpd_arbiter
// Brief    : Self-checking bench for fpd_arbiter. Two instances: one with a
//            combinational divider model (latency 0), one with a divider
//            model delayed by three cycles (latency 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpd_arbiter;

    typedef struct {
        int          idx;
        logic [34:0] val;   // {result[31:0], overflow, underflow, dbz}
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [127:0] req_a = '0;
    logic [127:0] req_b = '0;

    // latency-0 instance
    logic [3:0]  v0 = '0, rr0 = '0;
    logic [3:0]  rdy0, vld0;
    logic [31:0] res0, fa0, fb0, fres0;
    logic        ov0, un0, dbz0, busy0, fov0, fun0, fdbz0;
    logic [1:0]  gid0;

    // latency-3 instance
    logic [3:0]  v3 = '0, rr3 = '0;
    logic [3:0]  rdy3, vld3;
    logic [31:0] res3, fa3, fb3, fres3;
    logic        ov3, un3, dbz3, busy3, fov3, fun3, fdbz3;
    logic [1:0]  gid3;

    int n_cmp = 0;
    int n_err = 0;
    exp_t sb0[$];
    exp_t sb3[$];

    // Stand-in divider: exact for the 6/2 case, a fixed scramble otherwise.
    function automatic logic [34:0] div_model(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'h0)
            return {32'h7F800000, 1'b0, 1'b0, 1'b1};
        if (a == 32'h40C00000 && b == 32'h40000000)
            return {32'h40400000, 3'b000};
        return {a ^ {b[15:0], b[31:16]}, a[0] & b[0], a[1] ^ b[1], 1'b0};
    endfunction

    assign {fres0, fov0, fun0, fdbz0} = div_model(fa0, fb0);

    logic [31:0] a_d1, a_d2, a_d3, b_d1, b_d2, b_d3;
    always @(posedge clk) begin
        a_d1 <= fa3; a_d2 <= a_d1; a_d3 <= a_d2;
        b_d1 <= fb3; b_d2 <= b_d1; b_d3 <= b_d2;
    end
    assign {fres3, fov3, fun3, fdbz3} = div_model(a_d3, b_d3);

    fpd_arbiter #(.N_REQ(4), .FPD_LATENCY(0)) u_dut0 (
        .clock(clk), .reset(reset),
        .req_valid_in(v0), .req_ready_out(rdy0),
        .req_a_in(req_a), .req_b_in(req_b),
        .rsp_valid_out(vld0), .rsp_ready_in(rr0),
        .rsp_result_out(res0), .rsp_overflow_out(ov0),
        .rsp_underflow_out(un0), .rsp_dbz_out(dbz0),
        .grant_id_out(gid0), .busy_out(busy0),
        .fpd_a_out(fa0), .fpd_b_out(fb0),
        .fpd_result_in(fres0), .fpd_overflow_in(fov0),
        .fpd_underflow_in(fun0), .fpd_dbz_in(fdbz0)
    );

    fpd_arbiter #(.N_REQ(4), .FPD_LATENCY(3)) u_dut3 (
        .clock(clk), .reset(reset),
        .req_valid_in(v3), .req_ready_out(rdy3),
        .req_a_in(req_a), .req_b_in(req_b),
        .rsp_valid_out(vld3), .rsp_ready_in(rr3),
        .rsp_result_out(res3), .rsp_overflow_out(ov3),
        .rsp_underflow_out(un3), .rsp_dbz_out(dbz3),
        .grant_id_out(gid3), .busy_out(busy3),
        .fpd_a_out(fa3), .fpd_b_out(fb3),
        .fpd_result_in(fres3), .fpd_overflow_in(fov3),
        .fpd_underflow_in(fun3), .fpd_dbz_in(fdbz3)
    );

    // Scoreboard for the latency-0 instance: pop on every accepted response.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (vld0 & rr0) != 4'b0) begin
            n_cmp++;
            if (sb0.size() == 0) begin
                n_err++;
                $display("FAIL sb0_unexpected rsp_valid=%b (no response expected)", vld0);
            end else begin
                e = sb0.pop_front();
                if (vld0 !== (4'b1 << e.idx) || {res0, ov0, un0, dbz0} !== e.val) begin
                    n_err++;
                    $display("FAIL sb0_rsp valid=%b want %b data=%h want %h",
                             vld0, 4'b1 << e.idx, {res0, ov0, un0, dbz0}, e.val);
                end
            end
        end
    end

    // Scoreboard for the latency-3 instance.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (vld3 & rr3) != 4'b0) begin
            n_cmp++;
            if (sb3.size() == 0) begin
                n_err++;
                $display("FAIL sb3_unexpected rsp_valid=%b (no response expected)", vld3);
            end else begin
                e = sb3.pop_front();
                if (vld3 !== (4'b1 << e.idx) || {res3, ov3, un3, dbz3} !== e.val) begin
                    n_err++;
                    $display("FAIL sb3_rsp valid=%b want %b data=%h want %h",
                             vld3, 4'b1 << e.idx, {res3, ov3, un3, dbz3}, e.val);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int id, input logic [31:0] a, input logic [31:0] b);
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
    endtask

    function automatic exp_t mk(input int id, input logic [127:0] ra, input logic [127:0] rb);
        exp_t e;
        e.idx = id;
        e.val = div_model(ra[id*32 +: 32], rb[id*32 +: 32]);
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b1; v0 = 4'hF; v3 = 4'hF; rr0 = '0; rr3 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (rdy0 !== 4'b0 || vld0 !== 4'b0 || busy0 !== 1'b0 || gid0 !== 2'd0) begin
            n_err++;
            $display("FAIL reset_ctrl0 rdy=%b vld=%b busy=%b gid=%0d want all 0", rdy0, vld0, busy0, gid0);
        end
        n_cmp++;
        if ({fa0, fb0, res0, ov0, un0, dbz0} !== '0) begin
            n_err++;
            $display("FAIL reset_data0 a=%h b=%h res=%h flags=%b%b%b want 0", fa0, fb0, res0, ov0, un0, dbz0);
        end
        n_cmp++;
        if (rdy3 !== 4'b0 || vld3 !== 4'b0 || busy3 !== 1'b0 || {fa3, res3} !== '0) begin
            n_err++;
            $display("FAIL reset_dut3 rdy=%b vld=%b busy=%b a=%h res=%h want 0", rdy3, vld3, busy3, fa3, res3);
        end
        tick();
        reset = 1'b0; v0 = '0; v3 = '0; rr0 = 4'hF; rr3 = 4'hF;
    endtask

    task automatic test_single(input int id, input logic [31:0] a, input logic [31:0] b);
        logic [34:0] ev;
        ev = div_model(a, b);
        tick();
        set_ops(id, a, b);
        v0 = 4'b1 << id;
        sb0.push_back(mk(id, req_a, req_b));
        @(negedge clk);
        n_cmp++;
        if (rdy0 !== (4'b1 << id)) begin
            n_err++;
            $display("FAIL single_ready rdy=%b want %b", rdy0, 4'b1 << id);
        end
        tick();
        v0 = '0;
        @(negedge clk);
        n_cmp++;
        if (vld0 !== 4'b0 || busy0 !== 1'b1 || fa0 !== a || fb0 !== b || gid0 !== 2'(id)) begin
            n_err++;
            $display("FAIL single_wait vld=%b busy=%b a=%h b=%h gid=%0d want 0000 1 %h %h %0d",
                     vld0, busy0, fa0, fb0, gid0, a, b, id);
        end
        @(negedge clk);
        n_cmp++;
        if (vld0 !== (4'b1 << id) || {res0, ov0, un0, dbz0} !== ev) begin
            n_err++;
            $display("FAIL single_rsp vld=%b data=%h want %b %h", vld0, {res0, ov0, un0, dbz0}, 4'b1 << id, ev);
        end
        @(negedge clk);
        n_cmp++;
        if (busy0 !== 1'b0 || vld0 !== 4'b0) begin
            n_err++;
            $display("FAIL single_done busy=%b vld=%b want 0 0000", busy0, vld0);
        end
    endtask

    task automatic test_all_valid();
        int g = 0;
        logic [3:0] want;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++)
            set_ops(i, 32'h3F800001 + 32'(i * 7), 32'h40000003 + 32'(i * 5));
        for (int k = 0; k < 5; k++)
            sb0.push_back(mk(k % 4, req_a, req_b));
        v0 = 4'hF;
        for (int c = 0; c < 40 && g < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (busy0) begin
                if (rdy0 !== 4'b0) begin
                    n_err++;
                    $display("FAIL all_ready_busy rdy=%b want 0000", rdy0);
                end
            end else begin
                want = 4'b1 << (g % 4);
                if (rdy0 !== want) begin
                    n_err++;
                    $display("FAIL all_grant_order rdy=%b want %b", rdy0, want);
                end
                g++;
            end
            tick();
            if (g == 5) v0 = '0;
        end
        n_cmp++;
        if (g != 5) begin
            n_err++;
            $display("FAIL all_timeout grants=%0d want 5", g);
        end
        v0 = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [34:0] ev;
        set_ops(1, 32'h41200002, 32'h3FC00003);
        set_ops(0, 32'h42000001, 32'h40800001);
        ev = div_model(32'h41200002, 32'h3FC00003);
        tick();
        v0 = 4'b0010;
        sb0.push_back(mk(1, req_a, req_b));
        sb0.push_back(mk(0, req_a, req_b));
        @(negedge clk);
        n_cmp++;
        if (rdy0 !== 4'b0010) begin
            n_err++;
            $display("FAIL bp_ready rdy=%b want 0010", rdy0);
        end
        tick();
        v0 = 4'b0001;
        rr0 = 4'b1101;
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if (vld0 !== 4'b0010 || {res0, ov0, un0, dbz0} !== ev || busy0 !== 1'b1 || rdy0 !== 4'b0) begin
                n_err++;
                $display("FAIL bp_hold vld=%b data=%h busy=%b rdy=%b want 0010 %h 1 0000",
                         vld0, {res0, ov0, un0, dbz0}, busy0, rdy0, ev);
            end
        end
        tick();
        rr0 = 4'hF;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (busy0 !== 1'b0 || rdy0 !== 4'b0001) begin
            n_err++;
            $display("FAIL bp_release busy=%b rdy=%b want 0 0001", busy0, rdy0);
        end
        tick();
        v0 = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_latency3();
        logic [31:0] a, b;
        logic [34:0] ev;
        a = 32'h40490FDB;
        b = 32'h3F000001;
        ev = div_model(a, b);
        tick();
        set_ops(1, a, b);
        v3 = 4'b0010;
        sb3.push_back(mk(1, req_a, req_b));
        @(negedge clk);
        n_cmp++;
        if (rdy3 !== 4'b0010) begin
            n_err++;
            $display("FAIL lat3_ready rdy=%b want 0010", rdy3);
        end
        tick();
        v3 = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (fa3 !== a || fb3 !== b || vld3 !== 4'b0 || busy3 !== 1'b1) begin
                n_err++;
                $display("FAIL lat3_wait cyc=%0d a=%h b=%h vld=%b busy=%b want %h %h 0000 1",
                         c, fa3, fb3, vld3, busy3, a, b);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (vld3 !== 4'b0010 || {res3, ov3, un3, dbz3} !== ev) begin
            n_err++;
            $display("FAIL lat3_rsp vld=%b data=%h want 0010 %h", vld3, {res3, ov3, un3, dbz3}, ev);
        end
        @(negedge clk);
        n_cmp++;
        if (busy3 !== 1'b0) begin
            n_err++;
            $display("FAIL lat3_done busy=%b want 0", busy3);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        set_ops(1, 32'h3F800000, 32'h40400000);
        set_ops(0, 32'h40A00000, 32'h40000000);
        v0 = 4'b0010;
        @(negedge clk);
        n_cmp++;
        if (rdy0 !== 4'b0010) begin
            n_err++;
            $display("FAIL rmid_ready rdy=%b want 0010", rdy0);
        end
        tick();
        v0 = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy0 !== 1'b0 || vld0 !== 4'b0 || rdy0 !== 4'b0 ||
            {fa0, fb0, res0, ov0, un0, dbz0, gid0} !== '0) begin
            n_err++;
            $display("FAIL rmid_idle busy=%b vld=%b a=%h res=%h gid=%0d want all 0", busy0, vld0, fa0, res0, gid0);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (vld0 !== 4'b0) begin
                n_err++;
                $display("FAIL rmid_no_rsp vld=%b want 0000", vld0);
            end
        end
        tick();
        v0 = 4'hF;
        sb0.push_back(mk(0, req_a, req_b));
        @(negedge clk);
        n_cmp++;
        if (rdy0 !== 4'b0001) begin
            n_err++;
            $display("FAIL rmid_regrant rdy=%b want 0001", rdy0);
        end
        tick();
        v0 = '0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single(0, 32'h40C00000, 32'h40000000);
        test_single(2, 32'h3F800000, 32'h00000000);
        test_all_valid();
        test_backpressure();
        test_latency3();
        test_reset_mid();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (sb0.size() != 0 || sb3.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain left0=%0d left3=%0d want 0 0", sb0.size(), sb3.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
